// File: rtl/multicycle_control.sv
// Main control FSM for the multi-cycle MIPS datapath, with memory ready handshake and retired-instruction counter.
// Optional feature: define MULTICYCLE_ADDI_EN to decode addi (opcode 001000) through ADDIEX/ADDIWB.
module multicycle_control #(
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [5:0]           Op,
    input  logic                 Zero,
    input  logic                 MemReady,
    output logic                 MemRead,
    output logic                 MemWrite,
    output logic                 IRWrite,
    output logic                 RegWrite,
    output logic                 RegDst,
    output logic                 MemtoReg,
    output logic                 IorD,
    output logic                 AluSrcA,
    output logic [1:0]           AluSrcB,
    output logic [1:0]           AluOp,
    output logic [1:0]           PCSrc,
    output logic                 PCEn,
    output logic [3:0]           State,
    output logic                 IllegalOp,
    output logic [CNT_WIDTH-1:0] InstrCount
);

    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
`ifdef MULTICYCLE_ADDI_EN
    localparam logic [5:0] OP_ADDI = 6'b001000;
`endif

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTYPEEX = 4'd6,
        RTYPEWB = 4'd7,
        BEQEX   = 4'd8,
        JEX     = 4'd9,
        ADDIEX  = 4'd10,
        ADDIWB  = 4'd11
    } state_t;

    state_t curState;
    logic   isLoad;     // lw vs sw, captured in DECODE since Op is only valid there
    logic   pcWrite;
    logic   branch;
    logic   retire;
    logic   opLegal;

    assign State = curState;
    assign PCEn  = pcWrite | (branch & Zero);

    // Opcode legality for the DECODE illegal-op pulse
    always_comb begin
        opLegal = 1'b0;
        case (Op)
            OP_LW, OP_SW, OP_R, OP_BEQ, OP_J: opLegal = 1'b1;
`ifdef MULTICYCLE_ADDI_EN
            OP_ADDI:                          opLegal = 1'b1;
`endif
            default:                          opLegal = 1'b0;
        endcase
    end

    // State register, lw/sw flag and retired-instruction counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            curState   <= FETCH;
            isLoad     <= 1'b0;
            InstrCount <= '0;
        end else begin
            if (retire) InstrCount <= InstrCount + CNT_WIDTH'(1);
            case (curState)
                FETCH:   if (MemReady) curState <= DECODE;
                DECODE: begin
                    isLoad <= (Op == OP_LW);
                    case (Op)
                        OP_LW, OP_SW: curState <= MEMADR;
                        OP_R:         curState <= RTYPEEX;
                        OP_BEQ:       curState <= BEQEX;
                        OP_J:         curState <= JEX;
`ifdef MULTICYCLE_ADDI_EN
                        OP_ADDI:      curState <= ADDIEX;
`endif
                        default:      curState <= FETCH;
                    endcase
                end
                MEMADR:  curState <= isLoad ? MEMRD : MEMWR;
                MEMRD:   if (MemReady) curState <= MEMWB;
                MEMWR:   if (MemReady) curState <= FETCH;
                RTYPEEX: curState <= RTYPEWB;
`ifdef MULTICYCLE_ADDI_EN
                ADDIEX:  curState <= ADDIWB;
`endif
                default: curState <= FETCH;
            endcase
        end
    end

    // Per-state control decode; unlisted outputs stay 0
    always_comb begin
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        IRWrite   = 1'b0;
        RegWrite  = 1'b0;
        RegDst    = 1'b0;
        MemtoReg  = 1'b0;
        IorD      = 1'b0;
        AluSrcA   = 1'b0;
        AluSrcB   = 2'b00;
        AluOp     = 2'b00;
        PCSrc     = 2'b00;
        IllegalOp = 1'b0;
        pcWrite   = 1'b0;
        branch    = 1'b0;
        retire    = 1'b0;
        case (curState)
            FETCH: begin
                MemRead = 1'b1;
                AluSrcB = 2'b01;
                IRWrite = MemReady;
                pcWrite = MemReady;
            end
            DECODE: begin
                AluSrcB   = 2'b11;
                IllegalOp = ~opLegal;
            end
            MEMADR: begin
                AluSrcA = 1'b1;
                AluSrcB = 2'b10;
            end
            MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            MEMWB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
                retire   = 1'b1;
            end
            MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                retire   = MemReady;
            end
            RTYPEEX: begin
                AluSrcA = 1'b1;
                AluOp   = 2'b10;
            end
            RTYPEWB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
                retire   = 1'b1;
            end
            BEQEX: begin
                AluSrcA = 1'b1;
                AluOp   = 2'b01;
                PCSrc   = 2'b01;
                branch  = 1'b1;
                retire  = 1'b1;
            end
            JEX: begin
                PCSrc   = 2'b10;
                pcWrite = 1'b1;
                retire  = 1'b1;
            end
`ifdef MULTICYCLE_ADDI_EN
            ADDIEX: begin
                AluSrcA = 1'b1;
                AluSrcB = 2'b10;
            end
            ADDIWB: begin
                RegWrite = 1'b1;
                retire   = 1'b1;
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: instruction-level model pushes per-cycle expectations, a monitor compares.
module tb_multicycle_control;

    localparam int unsigned CW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [5:0]    Op;
    logic          Zero;
    logic          MemReady;
    logic          MemRead, MemWrite, IRWrite, RegWrite, RegDst, MemtoReg, IorD, AluSrcA;
    logic [1:0]    AluSrcB, AluOp, PCSrc;
    logic          PCEn, IllegalOp;
    logic [3:0]    State;
    logic [CW-1:0] InstrCount;

    multicycle_control #(.CNT_WIDTH(CW)) dut (
        .clk(clk), .reset(reset), .Op(Op), .Zero(Zero), .MemReady(MemReady),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
        .RegDst(RegDst), .MemtoReg(MemtoReg), .IorD(IorD), .AluSrcA(AluSrcA),
        .AluSrcB(AluSrcB), .AluOp(AluOp), .PCSrc(PCSrc), .PCEn(PCEn), .State(State),
        .IllegalOp(IllegalOp), .InstrCount(InstrCount)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]    state;
        logic          memRead, memWrite, irWrite, regWrite, regDst, memtoReg, iorD, aluSrcA;
        logic [1:0]    aluSrcB, aluOp, pcSrc;
        logic          pcEn, illegalOp;
        logic [CW-1:0] count;
    } obs_t;

    typedef enum int {K_LW, K_SW, K_R, K_BEQ, K_J, K_ADDI, K_ILL} kind_t;

    obs_t sb[$];
    int   nTests = 0;
    int   nFail  = 0;
    int   retired = 0;
    int   cycleNo = 0;

    function automatic kind_t kindOf(input logic [5:0] op);
        case (op)
            6'b100011: return K_LW;
            6'b101011: return K_SW;
            6'b000000: return K_R;
            6'b000100: return K_BEQ;
            6'b000010: return K_J;
`ifdef MULTICYCLE_ADDI_EN
            6'b001000: return K_ADDI;
`endif
            default:   return K_ILL;
        endcase
    endfunction

    function automatic obs_t blank(input int st);
        obs_t e = '0;
        e.state = 4'(st);
        e.count = CW'(retired % (1 << CW));
        return e;
    endfunction

    // Drive one cycle of inputs and queue what the DUT must show for it
    task automatic cycle(input obs_t e, input logic [5:0] op, input logic mr, input logic z);
        @(posedge clk);
        #1;
        Op = op; MemReady = mr; Zero = z;
        sb.push_back(e);
    endtask

    task automatic chk(input string name, input int act, input int req);
        nTests++;
        if (act != req) begin
            nFail++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // One instruction from FETCH to FETCH; abortMemrd asserts reset inside MEMRD
    task automatic runInstr(input logic [5:0] op, input int fw, input int mw, input logic z,
                            input bit abortMemrd);
        obs_t  e;
        kind_t k = kindOf(op);
        for (int i = 0; i < fw; i++) begin
            e = blank(0); e.memRead = 1; e.aluSrcB = 2'b01;
            cycle(e, 6'($urandom), 1'b0, 1'($urandom));
        end
        e = blank(0); e.memRead = 1; e.aluSrcB = 2'b01; e.irWrite = 1; e.pcEn = 1;
        cycle(e, 6'($urandom), 1'b1, 1'($urandom));
        e = blank(1); e.aluSrcB = 2'b11; e.illegalOp = (k == K_ILL);
        cycle(e, op, 1'($urandom), 1'($urandom));
        case (k)
            K_LW, K_SW: begin
                e = blank(2); e.aluSrcA = 1; e.aluSrcB = 2'b10;
                cycle(e, 6'($urandom), 1'($urandom), 1'($urandom));
                if (abortMemrd) begin
                    @(posedge clk);
                    #1; MemReady = 1'b0;
                    #2; reset = 1'b1;
                    #1;
                    retired = 0;
                    chk("rst_state", int'(State), 0);
                    chk("rst_count", int'(InstrCount), 0);
                    chk("rst_memread", int'(MemRead), 1);
                    chk("rst_alusrcb", int'(AluSrcB), 1);
                    chk("rst_irwrite", int'(IRWrite), 0);
                    @(posedge clk);
                    #1; reset = 1'b0;
                    return;
                end
                for (int i = 0; i <= mw; i++) begin
                    if (k == K_LW) begin
                        e = blank(3); e.memRead = 1; e.iorD = 1;
                    end else begin
                        e = blank(5); e.memWrite = 1; e.iorD = 1;
                    end
                    cycle(e, 6'($urandom), (i == mw), 1'($urandom));
                end
                if (k == K_LW) begin
                    e = blank(4); e.regWrite = 1; e.memtoReg = 1;
                    cycle(e, 6'($urandom), 1'($urandom), 1'($urandom));
                end
                retired++;
            end
            K_R: begin
                e = blank(6); e.aluSrcA = 1; e.aluOp = 2'b10;
                cycle(e, 6'($urandom), 1'($urandom), 1'($urandom));
                e = blank(7); e.regWrite = 1; e.regDst = 1;
                cycle(e, 6'($urandom), 1'($urandom), 1'($urandom));
                retired++;
            end
            K_BEQ: begin
                e = blank(8); e.aluSrcA = 1; e.aluOp = 2'b01; e.pcSrc = 2'b01; e.pcEn = z;
                cycle(e, 6'($urandom), 1'($urandom), z);
                retired++;
            end
            K_J: begin
                e = blank(9); e.pcSrc = 2'b10; e.pcEn = 1;
                cycle(e, 6'($urandom), 1'($urandom), 1'($urandom));
                retired++;
            end
            K_ADDI: begin
                e = blank(10); e.aluSrcA = 1; e.aluSrcB = 2'b10;
                cycle(e, 6'($urandom), 1'($urandom), 1'($urandom));
                e = blank(11); e.regWrite = 1;
                cycle(e, 6'($urandom), 1'($urandom), 1'($urandom));
                retired++;
            end
            default: ;
        endcase
    endtask

    // Monitor: compare the DUT against every queued expectation on the falling edge
    initial begin
        obs_t exp_o, act;
        forever begin
            @(negedge clk);
            cycleNo++;
            if (sb.size() > 0) begin
                exp_o = sb.pop_front();
                act = '{State, MemRead, MemWrite, IRWrite, RegWrite, RegDst, MemtoReg, IorD,
                        AluSrcA, AluSrcB, AluOp, PCSrc, PCEn, IllegalOp, InstrCount};
                nTests++;
                if (act !== exp_o) begin
                    nFail++;
                    $display("FAIL cycle%0d st%0d: got %h expected %h", cycleNo,
                             exp_o.state, act, exp_o);
                end
            end
        end
    end

    initial begin
        logic [5:0] rop;
        int         pick;
        reset = 1'b1; Op = '0; Zero = 1'b0; MemReady = 1'b0;
        #1;
        chk("init_state", int'(State), 0);
        chk("init_count", int'(InstrCount), 0);
        chk("init_memread", int'(MemRead), 1);
        @(posedge clk);
        #1; reset = 1'b0;

        runInstr(6'b100011, 0, 0, 1'b0, 1'b0);   // lw, no waits
        runInstr(6'b101011, 0, 3, 1'b0, 1'b0);   // sw, 3 wait cycles
        runInstr(6'b000100, 1, 0, 1'b1, 1'b0);   // beq taken
        runInstr(6'b000100, 0, 0, 1'b0, 1'b0);   // beq not taken
        runInstr(6'b000000, 2, 0, 1'b0, 1'b0);   // R-type
        runInstr(6'b000010, 0, 0, 1'b0, 1'b0);   // j
        runInstr(6'b111111, 0, 0, 1'b0, 1'b0);   // illegal
        runInstr(6'b001000, 0, 0, 1'b0, 1'b0);   // addi (illegal unless enabled)
        runInstr(6'b100011, 0, 2, 1'b0, 1'b1);   // lw abandoned by reset

        for (int n = 0; n < 60; n++) begin
            pick = int'($urandom_range(0, 6));
            case (pick)
                0: rop = 6'b100011;
                1: rop = 6'b101011;
                2: rop = 6'b000000;
                3: rop = 6'b000100;
                4: rop = 6'b000010;
                5: rop = 6'b001000;
                default: rop = 6'($urandom);
            endcase
            runInstr(rop, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
                     1'($urandom), 1'b0);
        end

        repeat (3) @(posedge clk);
        chk("sb_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Main control finite state machine for the multi-cycle MIPS variant. Decodes the 6-bit opcode and sequences the shared ALU, memory port, instruction register, PC and register file across multiple cycles. Drives the 2-bit `AluOp` field into the existing ALU-control decoder:

- `00`: add, for address and PC arithmetic.
- `01`: subtract, for beq.
- `10`: R-type, decoded from the function field.

It also handles a ready handshake with the shared instruction/data memory and keeps a retired-instruction counter.

## Interface
Parameters:
- `CNT_WIDTH`, default 16: width of the retired-instruction counter.

Ports:
- `clk` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: asynchronous, active-high; forces FETCH and zeroes the counter.
- `Op` in 6: opcode, `IR[31:26]`; sampled in DECODE.
- `Zero` in 1: ALU zero flag.
- `MemReady` in 1: memory completes the current access this cycle.
- `MemRead` out 1: memory read request.
- `MemWrite` out 1: memory write request.
- `IRWrite` out 1: load instruction register.
- `RegWrite` out 1: register-file write enable.
- `RegDst` out 1: write-register select; 1 = rd, 0 = rt.
- `MemtoReg` out 1: write-data select; 1 = memory data, 0 = ALUOut.
- `IorD` out 1: memory address select; 1 = ALUOut, 0 = PC.
- `AluSrcA` out 1: ALU A select; 1 = register A, 0 = PC.
- `AluSrcB` out 2: ALU B select; 00 = B, 01 = const 4, 10 = sign-extended immediate, 11 = shifted immediate.
- `AluOp` out 2: to ALU control.
- `PCSrc` out 2: PC source; 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `PCEn` out 1: PC load, equal to `PCWrite | (Branch & Zero)`.
- `State` out 4: current state encoding, for debug.
- `IllegalOp` out 1: one-cycle pulse on an undecodable opcode.
- `InstrCount` out `CNT_WIDTH`: count of retired instructions.

## Operation
State encoding: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, RTYPEEX 6, RTYPEWB 7, BEQEX 8, JEX 9, ADDIEX 10, ADDIWB 11.

Outputs are decoded combinationally from `State`, plus `MemReady`/`Zero` where listed. Any output not listed for a state is driven 0.

Per-state outputs and next state:
- **FETCH**: `MemRead=1`, `IorD=0`, `AluSrcA=0`, `AluSrcB=01`, `AluOp=00`, `PCSrc=00`.
  - `IRWrite` and `PCWrite` equal `MemReady`.
  - Next: DECODE if `MemReady`, else hold.
- **DECODE**: `AluSrcA=0`, `AluSrcB=11`, `AluOp=00` (computes the branch target).
  - `Op` 100011 (lw) or 101011 (sw) → MEMADR.
  - `Op` 000000 (R-type) → RTYPEEX.
  - `Op` 000100 (beq) → BEQEX.
  - `Op` 000010 (j) → JEX.
  - `Op` 001000 (addi) → ADDIEX (macro only).
  - Any other opcode: `IllegalOp=1` this cycle → FETCH; the instruction is not counted.
- **MEMADR**: `AluSrcA=1`, `AluSrcB=10`, `AluOp=00`. Next: lw → MEMRD, sw → MEMWR.
- **MEMRD**: `MemRead=1`, `IorD=1`. Hold until `MemReady`, then → MEMWB.
- **MEMWB**: `RegWrite=1`, `RegDst=0`, `MemtoReg=1`. Retires; → FETCH.
- **MEMWR**: `MemWrite=1`, `IorD=1`. Hold until `MemReady`; then retires → FETCH. `MemWrite` stays high for every waiting cycle.
- **RTYPEEX**: `AluSrcA=1`, `AluSrcB=00`, `AluOp=10`. → RTYPEWB.
- **RTYPEWB**: `RegWrite=1`, `RegDst=1`, `MemtoReg=0`. Retires; → FETCH.
- **BEQEX**: `AluSrcA=1`, `AluSrcB=00`, `AluOp=01`, `PCSrc=01`, `Branch=1`. Retires; → FETCH.
- **JEX**: `PCSrc=10`, `PCWrite=1`. Retires; → FETCH.
- **ADDIEX**: `AluSrcA=1`, `AluSrcB=10`, `AluOp=00`. → ADDIWB.
- **ADDIWB**: `RegWrite=1`, `RegDst=0`, `MemtoReg=0`. Retires; → FETCH.
- Unused encodings 12–15 → FETCH next cycle, with all outputs 0.

Retired-instruction counter:
- `InstrCount` increments by 1 on the clock edge leaving a retiring state.
- Wraps modulo 2^`CNT_WIDTH` with no saturation.

## Timing
- **Reset**: `State=0` (FETCH) and `InstrCount=0` immediately on assertion, without waiting for a clock edge.
  - Output values during reset are the FETCH decode.
  - Asserting reset mid-instruction abandons that instruction with no count.
- **Latency** with `MemReady` tied high, counted in cycles from FETCH to the next FETCH:

| Instruction | Cycles |
|---|---|
| lw | 5 |
| sw | 4 |
| R-type | 4 |
| addi | 4 |
| beq | 3 |
| j | 3 |
| illegal opcode | 2 |

- **Memory waits**: each memory state adds one cycle per cycle `MemReady=0`.
- **MemReady sampling**: `MemReady` is sampled only in FETCH, MEMRD and MEMWR; in all other states it is ignored.
- **Branch**: `PCEn` in BEQEX follows `Zero` combinationally in the same cycle.

## Configuration
- `MULTICYCLE_ADDI_EN` defined: the addi opcode 001000 is decoded, and ADDIEX/ADDIWB exist.
- Not defined: 001000 is illegal (`IllegalOp` pulse, return to FETCH, no count), and encodings 10 and 11 behave as unused.

## Test plan
- **Reset:** assert reset mid-MEMRD.
  - `State` goes to 0 immediately, `InstrCount=0`.
  - FETCH outputs appear: `MemRead=1`, `AluSrcB=01`.
- **lw without waits:** `Op=100011`, `MemReady=1`.
  - State sequence 0,1,2,3,4,0.
  - `RegWrite=1` with `MemtoReg=1` in state 4; `InstrCount` goes 0→1.
- **sw with waits:** `Op=101011`, `MemReady` held low 3 cycles in MEMWR.
  - `MemWrite` is high for 4 cycles; 7 cycles total; count +1.
- **beq both outcomes:** `Op=000100`.
  - With `Zero=1`: `PCEn=1` and `PCSrc=01` in BEQEX.
  - With `Zero=0`: `PCEn=0`.
  - `AluOp=01` in both cases.
- **R-type and j:**
  - R-type: `AluOp=10` in RTYPEEX, then `RegDst=1`/`RegWrite=1`.
  - j: `PCSrc=10` and `PCEn=1` in JEX.
- **Illegal opcode and counter wrap:** `Op=111111` gives an `IllegalOp` pulse in DECODE, back in FETCH after 2 cycles, count unchanged.
  - Opcode 001000 with the macro off gives the same result.
  - `CNT_WIDTH=4`: after 16 retired instructions, `InstrCount=0`.
